// File: rtl/mem_stage_pipe.sv
// MEM stage: handshaked variable-latency data-memory access, watchdog and MEM/WB register.
// Latency: non-memory ops 0 extra cycles; memory ops stall (ready=0) from request until ack or timeout.
module mem_stage_pipe #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int DEST_W    = 4,
  parameter int ADDR_BASE = 1024,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              ready,
  output logic              err,
  output logic              wb_en_hazard,
  output logic [DEST_W-1:0] dest_hazard,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] mem_res_out,
  output logic [DEST_W-1:0] dest_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                wb_en_q, wb_en_d;
  logic                mem_r_en_q, mem_r_en_d;
  logic [DATA_W-1:0]   alu_res_q, alu_res_d;
  logic [DATA_W-1:0]   mem_res_q, mem_res_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic                access;

  assign access = mem_r_en_in | mem_w_en_in;
  assign ready  = (state_q == DONE) || ((state_q == IDLE) && !access);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rbuf_d      = rbuf_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_w_en_in;
          // Word address; underflow below the base wraps silently.
          mem_addr_d  = ADDR_W'((alu_res_in - DATA_W'(ADDR_BASE)) >> 2);
          mem_wdata_d = val_rm_in;
          cnt_d       = '0;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          rbuf_d    = mem_we_q ? '0 : mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          rbuf_d    = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        // Holding DONE under freeze keeps the read result available until it is loaded.
        if (!freeze) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    alu_res_d  = alu_res_q;
    mem_res_d  = mem_res_q;
    dest_d     = dest_q;
    if (!freeze) begin
      if (ready) begin
        wb_en_d    = wb_en_in;
        mem_r_en_d = mem_r_en_in;
        alu_res_d  = alu_res_in;
        dest_d     = dest_in;
        mem_res_d  = (state_q == DONE) ? rbuf_q : '0;
      end else begin
        wb_en_d    = 1'b0;
        mem_r_en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rbuf_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      wb_en_q     <= 1'b0;
      mem_r_en_q  <= 1'b0;
      alu_res_q   <= '0;
      mem_res_q   <= '0;
      dest_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rbuf_q      <= rbuf_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      wb_en_q     <= wb_en_d;
      mem_r_en_q  <= mem_r_en_d;
      alu_res_q   <= alu_res_d;
      mem_res_q   <= mem_res_d;
      dest_q      <= dest_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign err          = err_q;
  assign wb_en_hazard = wb_en_in;
  assign dest_hazard  = dest_in;
  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_en_q;
  assign alu_res_out  = alu_res_q;
  assign mem_res_out  = mem_res_q;
  assign dest_out     = dest_q;

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
Parametrised memory-access stage for the ARM pipeline. It combines the MEM-stage datapath, a handshaked interface to a variable-latency data memory, and the MEM/WB pipeline register. Width, destination-tag size, address base and timeout are generalised. A stall FSM drives `ready`, and a watchdog flags a memory that never acknowledges. It sits between the EXE/MEM register and the WB stage; the hazard unit and the freeze logic consume `ready` and the hazard taps.

Parameters:
- DATA_W, 32: data and ALU-result width.
- ADDR_W, 16: width of the word address sent to memory.
- DEST_W, 4: destination register tag width.
- ADDR_BASE, 1024: byte offset subtracted from alu_res_in to form the memory address.
- TIMEOUT, 255: maximum BUSY cycles without mem_ack; range 1..65535.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  hold the pipeline register
- wb_en_in  in  1  write-back enable from EXE/MEM
- mem_r_en_in  in  1  load request
- mem_w_en_in  in  1  store request
- alu_res_in  in  DATA_W  effective address or ALU result
- val_rm_in  in  DATA_W  store data
- dest_in  in  DEST_W  destination tag
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  ADDR_W  word address, registered
- mem_wdata  out  DATA_W  store data, registered
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  memory completion, one-cycle pulse
- ready  out  1  stage can complete this cycle (combinational)
- err  out  1  sticky timeout flag
- wb_en_hazard  out  1  equals wb_en_in (combinational tap)
- dest_hazard  out  DEST_W  equals dest_in (combinational tap)
- wb_en_out  out  1  registered, to WB
- mem_r_en_out  out  1  registered, to WB
- alu_res_out  out  DATA_W  registered, to WB
- mem_res_out  out  DATA_W  registered, to WB
- dest_out  out  DEST_W  registered, to WB

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, err are 0; timeout counter is 0.
  - All registered WB outputs are 0.
  - Reset mid-access abandons the transaction; a later mem_ack with no outstanding request is ignored.
- Access = mem_r_en_in | mem_w_en_in. If both are 1, the write wins and mem_we=1.
- Address: mem_addr = ((alu_res_in - ADDR_BASE) >> 2) truncated to ADDR_W, computed modulo 2^DATA_W. An underflow wraps; it is not flagged.
- FSM states:
  - IDLE: no access -> stay, ready=1. Access -> BUSY at the next edge, ready=0. On that edge: mem_req<=1, mem_we, mem_addr and mem_wdata latched, counter cleared.
  - BUSY: ready=0, mem_req held at 1, address and data held stable.
    - mem_ack=1 -> DONE. On that edge mem_req<=0 and, for a read, mem_rdata is captured into an internal read buffer.
    - No ack -> counter increments. When counter==TIMEOUT-1 and no ack -> DONE. On that edge err<=1, read buffer<=0, mem_req<=0.
  - DONE: ready=1 for exactly one cycle, then -> IDLE. If freeze=1 in DONE, stay in DONE with ready=1 until freeze=0, so the result is not lost.
- Latency: when ack arrives in the first BUSY cycle, ready is low for 2 cycles (IDLE, BUSY) and high in the 3rd (DONE). Each extra wait cycle adds one.
- Upstream holds all *_in inputs stable while ready=0.
- Pipeline register, at each edge:
  - freeze=1: hold all outputs.
  - freeze=0 and ready=1: load wb_en_in, mem_r_en_in, alu_res_in, dest_in. mem_res_out <= read buffer in DONE, else 0.
  - freeze=0 and ready=0: load a bubble (wb_en_out=0, mem_r_en_out=0; other fields hold).
- A non-memory instruction completes with zero added latency; mem_req stays 0.
- err is cleared only by reset. It does not block later accesses.
- mem_ack while IDLE or DONE is ignored.

Test Plan:
- Reset, then a non-memory op (wb_en_in=1, alu_res_in=0x55, dest_in=3, no access) -> next edge wb_en_out=1, alu_res_out=0x55, dest_out=3, mem_req stays 0, ready=1 throughout.
- Load with alu_res_in=1032 and ack in the first BUSY cycle, mem_rdata=0xDEADBEEF -> mem_addr=2, mem_we=0, ready low for 2 cycles. After the DONE edge: mem_res_out=0xDEADBEEF, mem_r_en_out=1; wb_en_out=0 during the stall edges.
- Store with alu_res_in=1028, val_rm_in=0x1234 and ack after 5 BUSY cycles -> mem_we=1, mem_addr=1, mem_wdata=0x1234 stable for all 5 cycles; ready rises at cycle 7.
- Load with TIMEOUT=4 and no ack -> err=1 after 4 BUSY cycles, mem_res_out=0, mem_req drops. err remains 1 across a following successful load.
- freeze=1 held for 3 cycles in DONE -> ready stays 1, outputs hold. On release, the load result is written once and the FSM returns to IDLE.
- rst pulsed low in BUSY -> mem_req=0 and outputs 0 immediately. A mem_ack asserted after reset is ignored, and a fresh load then completes normally.
